// File: rtl/fifo_flops.sv
// ---------------------------------------------------------------------------
// fifo_flops
//
// Purpose:
//   Synchronous FIFO whose storage is a flip-flop register array. It has a
//   valid/ready handshake on both the push and pop sides. When the FIFO is
//   empty, a word offered on the push side is visible on the pop side in the
//   same cycle (combinational bypass). If the consumer takes that word in the
//   same cycle, it never touches storage. Registered occupancy and status are
//   reported together with their next-cycle values, so that upstream and
//   downstream credit logic can look one cycle ahead.
//
// Ports:
//   clk         in   1           rising-edge clock
//   rst         in   1           asynchronous, active-high reset
//   push_valid  in   1           producer offers push_data
//   push_ready  out  1           FIFO can accept a word (== !full)
//   push_data   in   DATA_WIDTH  word to push
//   pop_valid   out  1           pop_data is valid (!empty || push_valid)
//   pop_ready   in   1           consumer takes pop_data
//   pop_data    out  DATA_WIDTH  head word, or push_data while empty
//   full        out  1           registered, items == DEPTH
//   full_next   out  1           value full takes after the next edge
//   empty       out  1           registered, items == 0
//   empty_next  out  1           value empty takes after the next edge
//   items       out  CNT_WIDTH   registered count of stored words
//   items_next  out  CNT_WIDTH   items after the next edge
//   slots       out  CNT_WIDTH   registered free entries (DEPTH - items)
//   slots_next  out  CNT_WIDTH   slots after the next edge
// ---------------------------------------------------------------------------
module fifo_flops #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 13,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  full_next,
    output logic                  empty,
    output logic                  empty_next,
    output logic [CNT_WIDTH-1:0]  items,
    output logic [CNT_WIDTH-1:0]  items_next,
    output logic [CNT_WIDTH-1:0]  slots,
    output logic [CNT_WIDTH-1:0]  slots_next
);

    // DEPTH >= 2, so the pointer is always at least one bit wide.
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;

    logic push_accepted;
    logic pop_accepted;
    logic bypass;
    logic store_push;
    logic store_pop;

    // Handshake and data path. push_ready depends only on the registered
    // full flag, so it has no combinational path from pop_ready. While the
    // FIFO is empty, the pop side shows the push side directly.
    always_comb begin
        push_ready    = !full;
        pop_valid     = !empty || push_valid;
        pop_data      = empty ? push_data : mem[rd_ptr];

        push_accepted = push_valid && push_ready;
        pop_accepted  = pop_valid && pop_ready;

        // A word pushed into an empty FIFO and consumed in the same cycle
        // goes straight through. Neither storage nor the counters see it.
        bypass        = empty && push_valid && pop_ready;
        store_push    = push_accepted && !bypass;
        store_pop     = pop_accepted && !empty;
    end

    // Next-cycle occupancy. A stored push can only happen below DEPTH and a
    // stored pop only above zero, so the counter never wraps.
    always_comb begin
        items_next = items + CNT_WIDTH'(store_push) - CNT_WIDTH'(store_pop);
        slots_next = DEPTH_CNT - items_next;
        full_next  = (items_next == DEPTH_CNT);
        empty_next = (items_next == '0);
    end

    // Pointers and status registers. All status flags load from their
    // *_next values, so they can never disagree with each other. Pointers
    // wrap explicitly at DEPTH-1 because DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            items  <= '0;
            slots  <= DEPTH_CNT;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (store_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (store_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            items <= items_next;
            slots <= slots_next;
            full  <= full_next;
            empty <= empty_next;
        end
    end

    // Storage array. It is deliberately left out of reset: after a reset the
    // pointers and counters mark every entry as free, so the stale contents
    // can never be observed.
    always_ff @(posedge clk) begin
        if (store_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_fifo_flops.sv
// ---------------------------------------------------------------------------
// tb_fifo_flops
//
// Purpose:
//   Self-checking bench for fifo_flops with the default parameters
//   (DATA_WIDTH=8, DEPTH=13). A queue-based reference model tracks the
//   expected contents. Every cycle, all DUT outputs are compared against
//   that model. On top of this, a table of directed vectors and hand-written
//   sequences carries explicit expected constants for reset, bypass, fill,
//   drain, wrap and mid-stream reset. A randomized phase follows at the end.
// ---------------------------------------------------------------------------
module tb_fifo_flops;

    localparam int DW    = 8;
    localparam int DEPTH = 13;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          full;
    logic          full_next;
    logic          empty;
    logic          empty_next;
    logic [CW-1:0] items;
    logic [CW-1:0] items_next;
    logic [CW-1:0] slots;
    logic [CW-1:0] slots_next;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model: the words held in storage, oldest first.
    logic [DW-1:0] model_q[$];

    fifo_flops #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .pop_valid(pop_valid),
        .pop_ready(pop_ready),
        .pop_data(pop_data),
        .full(full),
        .full_next(full_next),
        .empty(empty),
        .empty_next(empty_next),
        .items(items),
        .items_next(items_next),
        .slots(slots),
        .slots_next(slots_next)
    );

    // 10 ns clock. Rising edges occur at 5, 15, 25 ... and inputs change on
    // the falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so that the run always ends, even if something stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point. It uses a 4-state compare, so X or Z on a
    // DUT output is also reported.
    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs on the falling edge, then let them settle.
    task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd,
                                 input logic pr);
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
    endtask

    // Decide, from the model, whether storage gains or loses a word this
    // cycle. A push into an empty FIFO that is popped in the same cycle
    // never reaches storage.
    task automatic modelMoves(output bit st_push, output bit st_pop);
        int sz;
        sz      = model_q.size();
        st_push = push_valid && (sz != DEPTH) && !((sz == 0) && pop_ready);
        st_pop  = pop_ready && (sz != 0);
    endtask

    // Compare every DUT output with the model. The next-state outputs are
    // skipped while reset is held.
    task automatic checkOutput(input bit check_next);
        int sz;
        int nsz;
        bit st_push;
        bit st_pop;
        logic [DW-1:0] exp_data;
        sz = model_q.size();
        check("items", 32'(items), 32'(sz));
        check("slots", 32'(slots), 32'(DEPTH - sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("push_ready", 32'(push_ready), 32'(sz != DEPTH));
        check("pop_valid", 32'(pop_valid), 32'((sz != 0) || push_valid));
        exp_data = (sz == 0) ? push_data : model_q[0];
        check("pop_data", 32'(pop_data), 32'(exp_data));
        if (check_next) begin
            modelMoves(st_push, st_pop);
            nsz = sz + int'(st_push) - int'(st_pop);
            check("items_next", 32'(items_next), 32'(nsz));
            check("slots_next", 32'(slots_next), 32'(DEPTH - nsz));
            check("full_next", 32'(full_next), 32'(nsz == DEPTH));
            check("empty_next", 32'(empty_next), 32'(nsz == 0));
        end
    endtask

    // Take the rising edge and update the model accordingly.
    task automatic stepClock();
        bit st_push;
        bit st_pop;
        modelMoves(st_push, st_pop);
        @(posedge clk);
        if (st_pop) void'(model_q.pop_front());
        if (st_push) model_q.push_back(push_data);
        #1;
    endtask

    task automatic cycle(input logic pv, input logic [DW-1:0] pd,
                         input logic pr);
        applyStimulus(pv, pd, pr);
        checkOutput(1'b1);
        stepClock();
    endtask

    // Directed vector: inputs, expected pop side before the edge, and
    // expected occupancy after the edge.
    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          pr;
        logic          exp_pop_valid;
        logic [DW-1:0] exp_pop_data;
        int            exp_items;
        logic          exp_empty;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1}; // idle
        vecs[1] = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 0, 1'b1}; // bypass
        vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1, 1'b0}; // push into empty
        vecs[3] = '{1'b0, 8'h99, 1'b1, 1'b1, 8'h11, 0, 1'b1}; // pop it
        vecs[4] = '{1'b1, 8'h21, 1'b0, 1'b1, 8'h21, 1, 1'b0};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h21, 2, 1'b0};
        vecs[6] = '{1'b1, 8'h23, 1'b1, 1'b1, 8'h21, 2, 1'b0}; // push + pop
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h23, 0, 1'b1};
        vecs[9] = '{1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A, 0, 1'b1}; // empty, no push

        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput(1'b1);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_items", 32'(items), 32'd0);
        check("reset_slots", 32'(slots), 32'd13);
        check("reset_pop_valid", 32'(pop_valid), 32'd0);
        check("reset_push_ready", 32'(push_ready), 32'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].pd, vecs[i].pr);
            checkOutput(1'b1);
            check($sformatf("vec%0d_pop_valid", i), 32'(pop_valid),
                  32'(vecs[i].exp_pop_valid));
            check($sformatf("vec%0d_pop_data", i), 32'(pop_data),
                  32'(vecs[i].exp_pop_data));
            stepClock();
            check($sformatf("vec%0d_items", i), 32'(items),
                  32'(vecs[i].exp_items));
            check($sformatf("vec%0d_empty", i), 32'(empty),
                  32'(vecs[i].exp_empty));
        end

        // ---------------- fill to DEPTH ----------------
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_items", 32'(items), 32'd13);
        check("fill_slots", 32'(slots), 32'd0);
        check("fill_push_ready", 32'(push_ready), 32'd0);

        // A push while full must be ignored.
        cycle(1'b1, 8'hFF, 1'b0);
        check("overfill_items", 32'(items), 32'd13);
        check("overfill_full", 32'(full), 32'd1);

        // ---------------- drain (read pointer wraps) ----------------
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput(1'b1);
            check($sformatf("drain%0d_pop_data", i), 32'(pop_data), 32'(i));
            check($sformatf("drain%0d_pop_valid", i), 32'(pop_valid), 32'd1);
            stepClock();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full", 32'(full), 32'd0);
        check("drain_items", 32'(items), 32'd0);
        check("drain_slots", 32'(slots), 32'd13);

        // Full with a simultaneous pop: the pop proceeds, the push is dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput(1'b1);
        check("fullpop_pop_data", 32'(pop_data), 32'h60);
        check("fullpop_items_next", 32'(items_next), 32'd12);
        stepClock();
        check("fullpop_items", 32'(items), 32'd12);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1);
        check("fullpop_drained", 32'(empty), 32'd1);

        // ---------------- mixed push/pop across wrap ----------------
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'hB0 + i), 1'b1);
            checkOutput(1'b1);
            check($sformatf("mixed%0d_pop_data", i), 32'(pop_data),
                  (i < 3) ? 32'(8'hA0 + i) : 32'(8'hB0 + i - 3));
            stepClock();
            check($sformatf("mixed%0d_items", i), 32'(items), 32'd3);
        end

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_items", 32'(items), 32'd0);
        check("midrst_slots", 32'(slots), 32'd13);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_pop_valid", 32'(pop_valid), 32'(push_valid));
        check("midrst_pop_data", 32'(pop_data), 32'(push_data));
        checkOutput(1'b0);
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput(1'b1);

        // ---------------- randomized traffic vs model ----------------
        // The push/pop probabilities change between phases, so the run
        // spends time near both the full and the empty boundary.
        for (int phase = 0; phase < 4; phase++) begin
            int push_pct;
            int pop_pct;
            case (phase)
                0: begin push_pct = 80; pop_pct = 30; end
                1: begin push_pct = 30; pop_pct = 80; end
                2: begin push_pct = 50; pop_pct = 50; end
                default: begin push_pct = 90; pop_pct = 10; end
            endcase
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(99) < push_pct),
                      8'($urandom_range(255)),
                      ($urandom_range(99) < pop_pct));
            end
        end
        checkOutput(1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/fifo_flops.md
Name: fifo_flops

Overview:
- Synchronous FIFO whose storage is a flip-flop register array, with a valid/ready handshake on both the push and pop sides.
- Has a combinational bypass: when empty, a pushed word is visible on the pop side in the same cycle.
- Reports registered occupancy and status (items, slots, full, empty) plus their next-cycle values for upstream and downstream credit and flow-control logic.

Parameters:
- DATA_WIDTH, 8, width of push_data and pop_data.
- DEPTH, 13, number of storage entries; any integer >= 2, not required to be a power of two.
- CNT_WIDTH, $clog2(DEPTH+1) (4 for the defaults), width of the items/slots counters; must be able to represent DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  producer offers push_data this cycle.
- push_ready  out  1  FIFO can accept a word; equals !full.
- push_data  in  DATA_WIDTH  word to push.
- pop_valid  out  1  pop_data is valid.
- pop_ready  in  1  consumer takes pop_data this cycle.
- pop_data  out  DATA_WIDTH  head word, or push_data when the FIFO is empty (bypass).
- full  out  1  registered; items == DEPTH.
- full_next  out  1  value full takes after the next clock edge.
- empty  out  1  registered; items == 0.
- empty_next  out  1  value empty takes after the next clock edge.
- items  out  CNT_WIDTH  registered count of stored words.
- items_next  out  CNT_WIDTH  items after the next clock edge.
- slots  out  CNT_WIDTH  registered free entries; DEPTH - items.
- slots_next  out  CNT_WIDTH  slots after the next clock edge.

Behaviour:
- Clock and reset (fixed): one clock, clk; reset rst is asynchronous and active-high.
- Reset state, applied immediately on assertion, including mid-operation:
  - read pointer = 0, write pointer = 0, items = 0, slots = DEPTH.
  - empty = 1, full = 0, push_ready = 1.
  - pop_valid = push_valid, pop_data = push_data (the bypass path stays active).
  - Storage array is not reset; any in-flight contents are discarded.
- Handshake rules:
  - push_ready = !full; it has no combinational dependence on pop_ready.
  - pop_valid = !empty || push_valid.
  - Push accepted when push_valid && push_ready.
  - Pop accepted when pop_valid && pop_ready.
- Bypass (empty && push_valid && pop_ready):
  - pop_data = push_data and pop_valid = 1 in the same cycle.
  - The word is consumed directly; storage, pointers and counters do not change; items stays 0 and empty stays 1.
- Push only: store push_data at the write pointer; write pointer advances; items += 1.
- Pop only (non-empty): pop_data = mem[read pointer]; read pointer advances; items -= 1.
- Simultaneous push and pop while non-empty and not full: write at the write pointer and read at the read pointer; both pointers advance; items unchanged.
- When full: push_ready = 0 and push_valid is ignored; no write occurs and items stays DEPTH. A pop in the same cycle still proceeds.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0. No power-of-two assumptions.
- Latency: a pushed word is visible on pop_data 0 cycles later if the FIFO is empty; otherwise after all older words have been popped.
- Next-state outputs:
  - items_next = items + push_accepted_to_storage - pop_from_storage, where bypass counts as neither.
  - slots_next = DEPTH - items_next.
  - full_next = (items_next == DEPTH); empty_next = (items_next == 0).
- Register consistency: full, empty, items and slots are registered from their *_next values and are always mutually consistent.
- pop_data when empty and push_valid = 0: equals push_data, which is don't-care to the consumer since pop_valid = 0.

Test Plan:
- Reset: assert rst for 1 cycle, release -> empty=1, full=0, items=0, slots=13, pop_valid=0 (push_valid=0), push_ready=1.
- Bypass: from empty, push_data=0x42, push_valid=1, pop_ready=1 for one edge -> pop_data=0x42 and pop_valid=1 combinationally; after the edge empty=1, items=0.
- Single push/pop: push 0x11 with pop_ready=0 -> items=1, empty=0, slots=12. Then push_valid=0, pop_ready=1 for one edge -> pop_data was 0x11 with pop_valid=1 before the edge; after it empty=1, items=0.
- Fill: push 0..12 on 13 consecutive edges with pop_ready=0 -> full=1, empty=0, items=13, slots=0, push_ready=0. Push 0xFF once more -> items stays 13 and contents are unchanged.
- Drain: pop_ready=1 for 13 edges -> pop_data sequence 0..12 in order (exercising pointer wrap); then empty=1, full=0, items=0, slots=13.
- Mixed: preload 3 words, then push and pop simultaneously for 20 cycles -> items stays 3, output order matches input order across wrap; assert rst mid-stream -> immediately empty=1, items=0.
